// File: rtl/hex_display_ctrl_pkg.sv
// hex_disp_pkg: register map, segment decode table and digit limit shared by the display controller
package hex_disp_pkg;
  localparam int MAX_DIGITS = 8;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_RAW = 2'd2;
  localparam logic [1:0] ADDR_BLINK_DIV = 2'd3;
  // Active-high gfedcba patterns, entry 0 is the lowest element (hex digit 0).
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/hex_display_ctrl_if.sv
// hex_display_ctrl_if: Avalon-MM slave bus (address, chipselect, write_n, writedata, readdata)
interface hex_display_ctrl_if;
  logic [1:0] address;
  logic chipselect;
  logic write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/hex_seg_decoder.sv
// hex_seg_decoder: combinational hex nibble to active-high gfedcba segment lookup (i_nib -> o_seg)
module hex_seg_decoder
  import hex_disp_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = SEG_LUT[i_nib];
endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: Avalon-MM seven-segment controller for up to eight digits.
// Ports: clk, reset_n (sync, active-low), bus (Avalon-MM slave), seg_out (digit d on [7d+6:7d]).
// Define HEX_DISP_BLINK_EN to build the blink timer (CTRL[8], BLINK_DIV); otherwise those read as 0.
module hex_display_ctrl
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLINK_DIV_RST = 25_000_000
) (
  input  logic clk,
  input  logic reset_n,
  hex_display_ctrl_if.slave bus,
  output logic [NUM_DIGITS*7-1:0] seg_out
);
  localparam int NW = NUM_DIGITS * 7;
  localparam int DW = NUM_DIGITS * 4;
  localparam logic [NW-1:0] SEG_OFF = {NW{SEG_ACTIVE_LOW != 0}};
  logic [DW-1:0] r_data;
  logic [NUM_DIGITS-1:0] r_mask;
  logic [NUM_DIGITS-1:0] r_flags;
  logic [6:0] r_raw [NUM_DIGITS];
  logic [NW-1:0] r_seg;
  logic [NW-1:0] w_next;
  logic [6:0] w_dec [NUM_DIGITS];
  logic w_wr, w_wr_data, w_wr_ctrl, w_wr_raw;
  logic w_blink, w_phase;
  logic [31:0] w_div;
  logic w_unused;
  assign w_wr = bus.chipselect && !bus.write_n;
  assign w_wr_data = w_wr && bus.address == ADDR_DATA;
  assign w_wr_ctrl = w_wr && bus.address == ADDR_CTRL;
  assign w_wr_raw = w_wr && bus.address == ADDR_RAW;
  assign w_unused = ^{bus.writedata, BLINK_DIV_RST};
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data <= '0;
      r_mask <= '1;
      r_flags <= '0;
      for (int d = 0; d < NUM_DIGITS; d++) r_raw[d] <= '0;
    end else begin
      if (w_wr_data) begin
        r_data <= bus.writedata[DW-1:0];
        r_flags <= '0;
      end
      if (w_wr_ctrl) r_mask <= bus.writedata[NUM_DIGITS-1:0];
      // Indices with no matching digit simply match nothing, so out-of-range writes are dropped.
      for (int d = 0; d < NUM_DIGITS; d++)
        if (w_wr_raw && bus.writedata[10:8] == 3'(d)) begin
          r_raw[d] <= bus.writedata[6:0];
          r_flags[d] <= 1'b1;
        end
    end
  end
`ifdef HEX_DISP_BLINK_EN
  logic r_blink, r_phase;
  logic [31:0] r_div, r_cnt;
  logic w_wr_div;
  assign w_wr_div = w_wr && bus.address == ADDR_BLINK_DIV;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_blink <= 1'b0;
      r_div <= 32'(BLINK_DIV_RST);
      r_cnt <= '0;
      r_phase <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_blink <= bus.writedata[8];
      if (w_wr_div) r_div <= bus.writedata;
      // Any divider change or blink disable restarts the half-period from the lit phase.
      if (w_wr_div || (w_wr_ctrl && !bus.writedata[8]) || !r_blink || r_div == '0) begin
        r_cnt <= '0;
        r_phase <= 1'b0;
      end else if (r_cnt == r_div - 32'd1) begin
        r_cnt <= '0;
        r_phase <= ~r_phase;
      end else r_cnt <= r_cnt + 32'd1;
    end
  end
  assign w_blink = r_blink;
  assign w_phase = r_phase;
  assign w_div = r_div;
`else
  assign w_blink = 1'b0;
  assign w_phase = 1'b0;
  assign w_div = '0;
`endif
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex_seg_decoder u_dec (.i_nib(r_data[4*g+:4]), .o_seg(w_dec[g]));
  end
  always_comb begin
    w_next = '0;
    for (int d = 0; d < NUM_DIGITS; d++)
      w_next[7*d+:7] = (!r_mask[d] || (w_blink && w_phase)) ? 7'h00 : r_flags[d] ? r_raw[d] : w_dec[d];
  end
  always_ff @(posedge clk) r_seg <= !reset_n ? SEG_OFF : w_next ^ SEG_OFF;
  assign seg_out = r_seg;
  always_comb
    bus.readdata = bus.address == ADDR_DATA ? 32'(r_data) :
                   bus.address == ADDR_CTRL ? {23'b0, w_blink, 8'(r_mask)} :
                   bus.address == ADDR_RAW ? {24'b0, 8'(r_flags)} : w_div;
endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: randomized self-checking bench with a behavioural display/register model
module tb_hex_display_ctrl;
  localparam int ND = 6;
  localparam int NW = ND * 7;
`ifdef HEX_DISP_BLINK_EN
  localparam bit BLINK_BUILT = 1'b1;
`else
  localparam bit BLINK_BUILT = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NW-1:0] seg_out;
  hex_display_ctrl_if bus ();
  hex_display_ctrl #(.NUM_DIGITS(ND), .SEG_ACTIVE_LOW(1), .BLINK_DIV_RST(25_000_000)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .seg_out(seg_out)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [31:0] m_data, m_div;
  logic [7:0] m_mask, m_flags;
  logic m_blink;
  int unsigned m_t;
  logic [6:0] m_raw [8];
  logic [NW-1:0] exp_seg;
  function automatic bit model_phase();
    return m_div == 0 ? 1'b0 : bit'((m_t / m_div) % 2);
  endfunction
  function automatic logic [NW-1:0] model_disp();
    logic [NW-1:0] s;
    logic [6:0] v;
    for (int d = 0; d < ND; d++) begin
      v = (!m_mask[d] || (m_blink && model_phase())) ? 7'h00 : m_flags[d] ? m_raw[d] : lut[m_data[4*d+:4]];
      s[7*d+:7] = ~v;
    end
    return s;
  endfunction
  function automatic logic [31:0] exp_rd(logic [1:0] a);
    return a == 2'd0 ? m_data : a == 2'd1 ? {23'b0, m_blink, m_mask} : a == 2'd2 ? {24'b0, m_flags} : m_div;
  endfunction
  task automatic model_reset();
    m_data = 0;
    m_mask = 8'h3F;
    m_blink = 1'b0;
    m_div = BLINK_BUILT ? 32'd25_000_000 : 32'd0;
    m_t = 0;
    m_flags = 0;
    for (int i = 0; i < 8; i++) m_raw[i] = 0;
  endtask
  task automatic model_edge();
    logic wr;
    logic [31:0] wd;
    int idx;
    wr = bus.chipselect && !bus.write_n;
    wd = bus.writedata;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (wr && (bus.address == 2'd3 || (bus.address == 2'd1 && !wd[8]))) m_t = 0;
    else if (m_blink) m_t++;
    if (wr && bus.address == 2'd0) begin
      m_data = wd & 32'h00FF_FFFF;
      m_flags = 0;
    end
    if (wr && bus.address == 2'd1) begin
      m_mask = wd[7:0] & 8'h3F;
      if (BLINK_BUILT) m_blink = wd[8];
    end
    if (wr && bus.address == 2'd2) begin
      idx = int'(wd[10:8]);
      if (idx < ND) begin
        m_raw[idx] = wd[6:0];
        m_flags[idx] = 1'b1;
      end
    end
    if (wr && bus.address == 2'd3 && BLINK_BUILT) m_div = wd;
  endtask
  task automatic step();
    logic [NW-1:0] pre;
    pre = model_disp();
    @(posedge clk);
    exp_seg = reset_n ? pre : '1;
    model_edge();
    #1;
  endtask
  task automatic bwrite(logic [1:0] a, logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    bus.address = a;
    bus.writedata = d;
    step();
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    checks++;
    if (seg_out !== {NW{1'b1}}) begin errors++; $display("FAIL reset_seg got %h exp %h", seg_out, {NW{1'b1}}); end
    reset_n = 1'b1;
    step();
    step();
    checks++;
    if (seg_out !== {ND{~7'h3F}}) begin errors++; $display("FAIL reset_zero got %h exp %h", seg_out, {ND{~7'h3F}}); end
    bus.address = 2'd1;
    #1;
    checks++;
    if (bus.readdata !== 32'h0000_003F) begin errors++; $display("FAIL reset_ctrl got %h exp %h", bus.readdata, 32'h3F); end
  endtask
  task automatic test_data();
    logic [31:0] d;
    bwrite(2'd0, 32'h00AB_C123);
    step();
    checks++;
    if (seg_out !== {~7'h77, ~7'h7C, ~7'h39, ~7'h06, ~7'h5B, ~7'h4F}) begin
      errors++; $display("FAIL data_fixed got %h exp %h", seg_out, {~7'h77, ~7'h7C, ~7'h39, ~7'h06, ~7'h5B, ~7'h4F});
    end
    bus.address = 2'd0;
    #1;
    checks++;
    if (bus.readdata !== 32'h00AB_C123) begin errors++; $display("FAIL data_read got %h exp %h", bus.readdata, 32'h00AB_C123); end
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      bwrite(2'd0, d);
      step();
      checks++;
      if (seg_out !== exp_seg) begin errors++; $display("FAIL data_rand_seg got %h exp %h", seg_out, exp_seg); end
      bus.address = 2'd0;
      #1;
      checks++;
      if (bus.readdata !== exp_rd(2'd0)) begin errors++; $display("FAIL data_rand_read got %h exp %h", bus.readdata, exp_rd(2'd0)); end
    end
  endtask
  task automatic test_raw();
    bwrite(2'd2, 32'h0000_0249);
    step();
    checks++;
    if (seg_out[20:14] !== ~7'h49 || seg_out !== exp_seg) begin errors++; $display("FAIL raw_seg got %h exp %h", seg_out, exp_seg); end
    bus.address = 2'd2;
    #1;
    checks++;
    if (bus.readdata !== 32'h4) begin errors++; $display("FAIL raw_flags got %h exp %h", bus.readdata, 32'h4); end
    bwrite(2'd2, 32'h0000_0755);
    step();
    checks++;
    if (seg_out !== exp_seg) begin errors++; $display("FAIL raw_idx7_seg got %h exp %h", seg_out, exp_seg); end
    bus.address = 2'd2;
    #1;
    checks++;
    if (bus.readdata !== 32'h4) begin errors++; $display("FAIL raw_idx7_flags got %h exp %h", bus.readdata, 32'h4); end
    bwrite(2'd0, 32'h0012_3456);
    step();
    checks++;
    if (seg_out !== exp_seg) begin errors++; $display("FAIL raw_clear_seg got %h exp %h", seg_out, exp_seg); end
    bus.address = 2'd2;
    #1;
    checks++;
    if (bus.readdata !== 32'h0) begin errors++; $display("FAIL raw_clear_flags got %h exp %h", bus.readdata, 32'h0); end
    for (int i = 0; i < 12; i++) begin
      bwrite(2'd2, {21'($urandom), 3'($urandom), 1'b0, 7'($urandom)});
      step();
      checks++;
      if (seg_out !== exp_seg) begin errors++; $display("FAIL raw_rand_seg got %h exp %h", seg_out, exp_seg); end
      bus.address = 2'd2;
      #1;
      checks++;
      if (bus.readdata !== exp_rd(2'd2)) begin errors++; $display("FAIL raw_rand_flags got %h exp %h", bus.readdata, exp_rd(2'd2)); end
    end
  endtask
  task automatic test_mask();
    bwrite(2'd1, 32'h0000_0001);
    step();
    checks++;
    if (seg_out[NW-1:7] !== {(ND-1){7'h7F}} || seg_out !== exp_seg) begin errors++; $display("FAIL mask_one got %h exp %h", seg_out, exp_seg); end
    for (int i = 0; i < 8; i++) begin
      bwrite(2'd1, {23'($urandom), 1'b0, 8'($urandom)});
      step();
      checks++;
      if (seg_out !== exp_seg) begin errors++; $display("FAIL mask_rand_seg got %h exp %h", seg_out, exp_seg); end
      bus.address = 2'd1;
      #1;
      checks++;
      if (bus.readdata !== exp_rd(2'd1)) begin errors++; $display("FAIL mask_rand_read got %h exp %h", bus.readdata, exp_rd(2'd1)); end
    end
    bwrite(2'd1, 32'h0000_003F);
  endtask
  task automatic test_blink();
    int n;
    bwrite(2'd3, 32'd4);
    bwrite(2'd1, 32'h0000_013F);
    for (int i = 0; i < 24; i++) begin
      step();
      checks++;
      if (seg_out !== exp_seg) begin errors++; $display("FAIL blink4_cyc%0d got %h exp %h", i, seg_out, exp_seg); end
    end
    bwrite(2'd3, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (seg_out !== exp_seg) begin errors++; $display("FAIL blink0_cyc%0d got %h exp %h", i, seg_out, exp_seg); end
    end
    bwrite(2'd3, 32'd3);
    n = 0;
    while (!model_phase() && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!model_phase()) begin errors++; $display("FAIL blink_no_blank got 0 exp 1"); end
    bwrite(2'd1, 32'h0000_003F);
    step();
    checks++;
    if (seg_out !== exp_seg || seg_out === {NW{1'b1}}) begin errors++; $display("FAIL blink_clear got %h exp %h", seg_out, exp_seg); end
    for (int r = 0; r < 6; r++) begin
      bwrite(2'd3, 32'($urandom_range(1, 5)));
      bwrite(2'd1, {23'b0, 1'b1, 2'b0, 6'($urandom)});
      for (int i = 0; i < 15; i++) begin
        step();
        checks++;
        if (seg_out !== exp_seg) begin errors++; $display("FAIL blink_rand got %h exp %h", seg_out, exp_seg); end
      end
    end
    bwrite(2'd1, 32'h0000_003F);
  endtask
  task automatic test_no_blink();
    bwrite(2'd1, 32'h0000_01FF);
    bwrite(2'd3, 32'd5);
    bus.address = 2'd1;
    #1;
    checks++;
    if (bus.readdata !== 32'h0000_003F) begin errors++; $display("FAIL noblink_ctrl got %h exp %h", bus.readdata, 32'h3F); end
    bus.address = 2'd3;
    #1;
    checks++;
    if (bus.readdata !== 32'h0) begin errors++; $display("FAIL noblink_div got %h exp %h", bus.readdata, 32'h0); end
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (seg_out !== exp_seg) begin errors++; $display("FAIL noblink_seg got %h exp %h", seg_out, exp_seg); end
    end
  endtask
  task automatic test_reset_mid();
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    bus.address = 2'd0;
    bus.writedata = 32'h0077_7777;
    reset_n = 1'b0;
    step();
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    reset_n = 1'b1;
    checks++;
    if (seg_out !== {NW{1'b1}}) begin errors++; $display("FAIL rstmid_seg got %h exp %h", seg_out, {NW{1'b1}}); end
    for (int a = 0; a < 4; a++) begin
      bus.address = 2'(a);
      #1;
      checks++;
      if (bus.readdata !== exp_rd(2'(a))) begin errors++; $display("FAIL rstmid_read%0d got %h exp %h", a, bus.readdata, exp_rd(2'(a))); end
    end
    step();
    checks++;
    if (seg_out !== {ND{~7'h3F}}) begin errors++; $display("FAIL rstmid_zero got %h exp %h", seg_out, {ND{~7'h3F}}); end
  endtask
  task automatic test_back_to_back();
    logic [1:0] a;
    for (int i = 0; i < 400; i++) begin
      a = 2'($urandom);
      bus.chipselect = 1'($urandom);
      bus.write_n = ($urandom % 4) == 0;
      bus.address = a;
      bus.writedata = a == 2'd3 ? 32'($urandom_range(0, 6)) : $urandom;
      reset_n = ($urandom % 64) != 0;
      step();
      reset_n = 1'b1;
      checks++;
      if (seg_out !== exp_seg) begin errors++; $display("FAIL b2b_seg cyc%0d got %h exp %h", i, seg_out, exp_seg); end
      bus.chipselect = 1'b0;
      bus.address = 2'($urandom);
      #1;
      checks++;
      if (bus.readdata !== exp_rd(bus.address)) begin errors++; $display("FAIL b2b_read cyc%0d got %h exp %h", i, bus.readdata, exp_rd(bus.address)); end
    end
  endtask
  initial begin
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.address = 2'd0;
    bus.writedata = '0;
    model_reset();
    exp_seg = '1;
    test_reset();
    test_data();
    test_raw();
    test_mask();
    if (BLINK_BUILT) test_blink();
    else test_no_blink();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
